// File: rtl/seq_pkg.sv
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared state, class and pc-select encodings for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_MEM    = 3'd4;
  localparam state_t ST_WB     = 3'd5;
  localparam state_t ST_WB2    = 3'd6;
  localparam state_t ST_HALT   = 3'd7;

  localparam logic [2:0] CLS_RTYPE  = 3'b000;
  localparam logic [2:0] CLS_BRANCH = 3'b001;
  localparam logic [2:0] CLS_LOGIC  = 3'b010;
  localparam logic [2:0] CLS_ITYPE  = 3'b011;
  localparam logic [2:0] CLS_LOAD   = 3'b100;
  localparam logic [2:0] CLS_STORE  = 3'b101;
  localparam logic [2:0] CLS_JUMP   = 3'b110;
  localparam logic [2:0] CLS_SYS    = 3'b111;

  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

  // Value presented to the ALU-op decoder whenever no instruction is executing
  localparam logic [2:0] ALU_IDLE_CLS = CLS_JUMP;
  localparam logic [1:0] ALU_IDLE_OP  = OP_HALT;

  function automatic logic is_swap(input logic [2:0] cls, input logic [1:0] op);
    return (cls == CLS_SYS) && (op == OP_SWAP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_timer.sv
// ============================================================================
// Module   : seq_timer
// Purpose  : Memory-ack timeout counter; expired marks the last allowed cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_timer #(
  parameter int MEM_TO_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam logic [7:0] c_LIMIT = 8'(MEM_TO_CYC - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (load) begin
      r_cnt <= 8'd0;
    end else if (tick && !expired) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expired = (r_cnt == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/seq_ctrl.sv
// ============================================================================
// Module   : seq_ctrl
// Purpose  : Multi-cycle instruction sequencer FSM with memory-ack timeout.
//            Optional perf counters (cyc_cnt/ret_cnt) under SEQ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_ctrl
  import seq_pkg::*;
#(
  parameter int MEM_TO_CYC = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       inst_req,
  input  logic       inst_ack,
  input  logic [8:0] inst,
  input  logic       zero,
  input  logic       mem_ack,
  output logic [2:0] alu_op,
  output logic [1:0] op_type,
  output logic       reg_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0] cyc_cnt,
  output logic [15:0] ret_cnt
`endif
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [8:0] r_ir;
  logic       r_err;
  logic [1:0] w_pc_sel;
  logic       w_timeout;
  logic       w_load;
  logic       w_tick;
  logic       w_expired;
  logic [2:0] w_cls;
  logic [1:0] w_op;
  logic       w_in_exec;
  logic       w_unused_ir;

  assign w_cls       = r_ir[8:6];
  assign w_op        = r_ir[5:4];
  assign w_unused_ir = ^r_ir[3:0];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_sel    = PCSEL_INC;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_FETCH;
      ST_FETCH:  if (inst_ack) w_state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (w_cls == CLS_JUMP) begin
          w_state_nxt = ST_FETCH;
          w_pc_sel    = PCSEL_JMP;
        end else if ((w_cls == CLS_SYS) && (w_op == OP_HALT)) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if ((w_cls == CLS_LOAD) || (w_cls == CLS_STORE)) begin
          w_state_nxt = ST_MEM;
        end else if (w_cls == CLS_BRANCH) begin
          w_state_nxt = ST_FETCH;
          w_pc_sel    = zero ? PCSEL_BR : PCSEL_INC;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        // An ack on the final allowed cycle wins over the timeout
        if (mem_ack) begin
          w_state_nxt = (w_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        end else if (w_expired) begin
          w_state_nxt = ST_HALT;
          w_timeout   = 1'b1;
        end
      end
      ST_WB:   w_state_nxt = is_swap(w_cls, w_op) ? ST_WB2 : ST_FETCH;
      ST_WB2:  w_state_nxt = ST_FETCH;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ir    <= 9'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_FETCH) && inst_ack) r_ir <= inst;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign w_load = (r_state == ST_EXEC) && (w_state_nxt == ST_MEM);
  assign w_tick = (r_state == ST_MEM);

  seq_timer #(
    .MEM_TO_CYC (MEM_TO_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .tick    (w_tick),
    .expired (w_expired)
  );

  assign w_in_exec = (r_state == ST_EXEC) || (r_state == ST_MEM) ||
                     (r_state == ST_WB)   || (r_state == ST_WB2);

  // Waiting in FETCH and the initial IDLE->FETCH step do not retire anything
  assign pc_en    = (w_state_nxt == ST_FETCH) && (r_state != ST_IDLE) &&
                    (r_state != ST_FETCH);
  assign pc_sel   = pc_en ? w_pc_sel : PCSEL_INC;
  assign inst_req = (r_state == ST_FETCH);
  assign reg_we   = (r_state == ST_WB) || (r_state == ST_WB2);
  assign mem_re   = (r_state == ST_MEM) && (w_cls == CLS_LOAD);
  assign mem_we   = (r_state == ST_MEM) && (w_cls == CLS_STORE);
  assign alu_op   = w_in_exec ? w_cls : ALU_IDLE_CLS;
  assign op_type  = w_in_exec ? w_op  : ALU_IDLE_OP;
  assign busy     = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign done     = (r_state == ST_HALT);
  assign err      = r_err;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] r_cyc_cnt;
  logic [15:0] r_ret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt <= 16'd0;
      r_ret_cnt <= 16'd0;
    end else begin
      if (busy)  r_cyc_cnt <= r_cyc_cnt + 16'd1;
      if (pc_en) r_ret_cnt <= r_ret_cnt + 16'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign ret_cnt = r_ret_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_ctrl.sv
// ============================================================================
// Module   : tb_seq_ctrl
// Purpose  : Scoreboard bench for seq_ctrl: strobe-cycle events vs. queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_ctrl;

  typedef struct packed {
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic [2:0] alu_op;
    logic [1:0] op_type;
    logic [7:0] lat;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       inst_req;
  logic       inst_ack;
  logic [8:0] inst;
  logic       zero;
  logic       mem_ack;
  logic [2:0] alu_op;
  logic [1:0] op_type;
  logic       reg_we;
  logic       mem_re;
  logic       mem_we;
  logic       pc_en;
  logic [1:0] pc_sel;
  logic       busy;
  logic       done;
  logic       err;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cyc_cnt;
  logic [15:0] ret_cnt;
`endif

  seq_ctrl #(.MEM_TO_CYC(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .inst_req (inst_req),
    .inst_ack (inst_ack),
    .inst     (inst),
    .zero     (zero),
    .mem_ack  (mem_ack),
    .alu_op   (alu_op),
    .op_type  (op_type),
    .reg_we   (reg_we),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .pc_en    (pc_en),
    .pc_sel   (pc_sel),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cyc_cnt  (cyc_cnt),
    .ret_cnt  (ret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ev_t expq[$];
  ev_t got;
  ev_t exp_ev;
  int  checks;
  int  errors;
  int  cyc;
  int  ack_cyc;
  int  mem_wait;
  int  mcnt;

  function automatic ev_t mk(input logic rw, input logic mr, input logic mw, input logic pe,
                             input logic [1:0] ps, input logic [2:0] a, input logic [1:0] o,
                             input int lat);
    ev_t e;
    e.reg_we  = rw;
    e.mem_re  = mr;
    e.mem_we  = mw;
    e.pc_en   = pe;
    e.pc_sel  = ps;
    e.alu_op  = a;
    e.op_type = o;
    e.lat     = 8'(lat);
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] g, input logic [15:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, g, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (!inst_req && n < 60) begin
      tick();
      n++;
    end
    if (!inst_req) begin
      checks++;
      errors++;
      $display("FAIL fetch_wait got=inst_req0 exp=inst_req1");
    end
  endtask

  task automatic fetch(input logic [8:0] instr);
    wait_fetch();
    inst     = instr;
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("done", {15'd0, done}, 16'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    ack_cyc  = 0;
    mem_wait = 0;
    mcnt     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    inst_ack = 1'b0;
    inst     = 9'd0;
    zero     = 1'b0;
    mem_ack  = 1'b0;

    fork
      // Monitor: every cycle with any strobe is one scoreboard event
      forever begin
        @(negedge clk);
        cyc++;
        if (inst_req && inst_ack) ack_cyc = cyc;
        if (reg_we || mem_re || mem_we || pc_en) begin
          got = mk(reg_we, mem_re, mem_we, pc_en, pc_sel, alu_op, op_type, cyc - ack_cyc);
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got=%h exp=none", got);
          end else begin
            exp_ev = expq.pop_front();
            if (got !== exp_ev) begin
              errors++;
              $display("FAIL event got=%h exp=%h", got, exp_ev);
            end
          end
        end
      end
      // Memory responder: ack on the (mem_wait+1)th strobe cycle, never if negative
      forever begin
        tick();
        if ((mem_re || mem_we) && mem_wait >= 0) begin
          mem_ack = (mcnt == mem_wait);
          mcnt++;
        end else begin
          mcnt    = 0;
          mem_ack = 1'b0;
        end
      end
    join_none

    repeat (3) tick();
    chk("rst_strobes", {11'd0, reg_we, mem_re, mem_we, pc_en, inst_req}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_alu", {11'd0, alu_op, op_type}, {11'd0, 3'b110, 2'b11});
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {15'd0, busy}, 16'd0);
    do_start();
    chk("fetch_busy", {15'd0, busy}, 16'd1);

    // ADD
    wait_fetch();
    expq.push_back(mk(1, 0, 0, 1, 2'b00, 3'b000, 2'b00, 3));
    fetch(9'b000_00_0101);
    // BEQ taken, then not taken
    wait_fetch();
    zero = 1'b1;
    expq.push_back(mk(0, 0, 0, 1, 2'b01, 3'b001, 2'b00, 2));
    fetch(9'b001_00_0000);
    wait_fetch();
    zero = 1'b0;
    expq.push_back(mk(0, 0, 0, 1, 2'b00, 3'b001, 2'b00, 2));
    fetch(9'b001_00_0000);
    // JUMP: pc_sel=10 in DECODE, ALU sees idle code
    wait_fetch();
    expq.push_back(mk(0, 0, 0, 1, 2'b10, 3'b110, 2'b11, 1));
    fetch(9'b110_01_0000);
    // SWAP
    wait_fetch();
    expq.push_back(mk(1, 0, 0, 0, 2'b00, 3'b111, 2'b10, 3));
    expq.push_back(mk(1, 0, 0, 1, 2'b00, 3'b111, 2'b10, 4));
    fetch(9'b111_10_0000);
    // LOAD, ack after 4 wait cycles
    wait_fetch();
    mem_wait = 4;
    for (int l = 3; l <= 7; l++) expq.push_back(mk(0, 1, 0, 0, 2'b00, 3'b100, 2'b01, l));
    expq.push_back(mk(1, 0, 0, 1, 2'b00, 3'b100, 2'b01, 8));
    fetch(9'b100_01_0000);
    // STORE, 0-wait
    wait_fetch();
    mem_wait = 0;
    expq.push_back(mk(0, 0, 1, 1, 2'b00, 3'b101, 2'b00, 3));
    fetch(9'b101_00_0000);
    // I-type with a stray inst_ack during DECODE that must not reload IR
    wait_fetch();
    expq.push_back(mk(1, 0, 0, 1, 2'b00, 3'b011, 2'b01, 3));
    fetch(9'b011_01_0000);
    inst     = 9'b100_00_0000;
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
    // HALT, sticky against start
    wait_fetch();
    fetch(9'b111_11_0000);
    wait_done();
    chk("halt_busy", {15'd0, busy}, 16'd0);
    chk("halt_err", {15'd0, err}, 16'd0);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk("halt_sticky", {14'd0, done, busy}, 16'd2);

    // Reset in the middle of a LOAD's MEM phase
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    wait_fetch();
    mem_wait = -1;
    expq.push_back(mk(0, 1, 0, 0, 2'b00, 3'b100, 2'b00, 3));
    expq.push_back(mk(0, 1, 0, 0, 2'b00, 3'b100, 2'b00, 4));
    fetch(9'b100_00_0000);
    repeat (3) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", {11'd0, reg_we, mem_re, mem_we, pc_en, inst_req}, 16'd0);
    chk("midrst_status", {13'd0, busy, done, err}, 16'd0);
    chk("midrst_alu", {11'd0, alu_op, op_type}, {11'd0, 3'b110, 2'b11});
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_idle", {14'd0, busy, inst_req}, 16'd0);
    do_start();
    wait_fetch();
    expq.push_back(mk(1, 0, 0, 1, 2'b00, 3'b010, 2'b00, 3));
    fetch(9'b010_00_0000);

    // LOAD acked on the very cycle the timeout would fire
    wait_fetch();
    mem_wait = 14;
    for (int l = 3; l <= 17; l++) expq.push_back(mk(0, 1, 0, 0, 2'b00, 3'b100, 2'b00, l));
    expq.push_back(mk(1, 0, 0, 1, 2'b00, 3'b100, 2'b00, 18));
    fetch(9'b100_00_0000);

    // STORE never acked: 15 MEM cycles then HALT with err
    wait_fetch();
    mem_wait = -1;
    for (int l = 3; l <= 17; l++) expq.push_back(mk(0, 0, 1, 0, 2'b00, 3'b101, 2'b00, l));
    fetch(9'b101_00_0000);
    wait_done();
    chk("to_err", {15'd0, err}, 16'd1);
    chk("to_mem_we", {15'd0, mem_we}, 16'd0);
    chk("to_busy", {15'd0, busy}, 16'd0);

    repeat (3) tick();
    chk("queue_empty", 16'(expq.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
